// File: rtl/seven_seg_pkg.sv
// Shared constants and the hex-to-segment decode used by the 7-segment scanner.
package seven_seg_pkg;

    // All segments off (active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Largest supported digit bank; narrower banks slice the low bits
    localparam int MAX_DIGITS = 16;

    // All anodes off (active-low)
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    // Active-low segment pattern for one hex nibble, bit order g..a
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h10;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;
            4'hD: pat = 7'h21;
            4'hE: pat = 7'h06;
            4'hF: pat = 7'h0E;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational nibble to active-low 7-segment decoder.
module hex_to_seven_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Pure table lookup, no state
    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment bank.
// The input word is captured once per frame so a digit never tears.
// Optional build macro SEVEN_SEG_LEADING_ZERO_BLANK_EN: blank every digit
// above the most-significant nonzero nibble when the frame is captured.
module seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_start
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST      = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST      = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_ALL_OFF = ANODE_OFF[NUM_DIGITS-1:0];

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] value_sh;
    logic [NUM_DIGITS-1:0]   en_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic [NUM_DIGITS-1:0]   en_load;
    logic                    slot_end;
    logic                    frame_end;
    logic                    lit;
    logic [3:0]              nibble;
    logic [6:0]              seg_dec;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic lz_seen;

    // Walk down from the top digit, disabling digits until the first nonzero nibble; digit 0 is never suppressed
    always_comb begin
        en_load = digit_en;
        lz_seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (value[4*i +: 4] != 4'h0) begin
                lz_seen = 1'b1;
            end
            if (!lz_seen) begin
                en_load[i] = 1'b0;
            end
        end
    end
`else
    assign en_load = digit_en;
`endif

    // Slot counter and digit index: cnt runs one slot, idx steps once per slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame shadow: capture the display word on the last cycle of the last slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_sh <= '0;
            en_sh    <= '0;
            dp_sh    <= '0;
        end else if (frame_end) begin
            value_sh <= value;
            en_sh    <= en_load;
            dp_sh    <= dp_in;
        end
    end

    assign nibble = value_sh[4*idx +: 4];
    assign lit    = (int'(cnt) >= BLANK_CYCLES) && en_sh[idx];

    hex_to_seven_seg u_dec (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    // Registered pin drivers: blank during the guard window or for disabled digits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode       <= ANODE_ALL_OFF;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_end;
            if (lit) begin
                anode <= ~(NUM_DIGITS'(1) << idx);
                seg   <= seg_dec;
                dp    <= ~dp_sh[idx];
            end else begin
                anode <= ANODE_ALL_OFF;
                seg   <= SEG_BLANK;
                dp    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner (4 digits, 4-cycle slots, 1 blank cycle).
module tb_seven_segment_scanner;

    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int BC    = 1;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  digit_en;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  anode;
    logic        frame_start;

    seven_segment_scanner #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .digit_en    (digit_en),
        .dp_in       (dp_in),
        .seg         (seg),
        .dp          (dp),
        .anode       (anode),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      en;
        logic [3:0]      dpm;
        logic [3:0]      vis;
        logic [3:0][6:0] segs;
    } rec_t;

    typedef struct {
        logic [3:0] anode;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    rec_t tbl[7];
    rec_t zrec;
    rec_t drv;
    rec_t shadow;
    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   s     = 0;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    localparam logic [3:0] VIS_0050 = 4'b0011;
    localparam logic [3:0] VIS_0000 = 4'b0001;
`else
    localparam logic [3:0] VIS_0050 = 4'b1111;
    localparam logic [3:0] VIS_0000 = 4'b1111;
`endif

    function automatic rec_t mk(input logic [15:0] v, input logic [3:0] en,
                                input logic [3:0] dpm, input logic [3:0] vis,
                                input logic [6:0] s3, input logic [6:0] s2,
                                input logic [6:0] s1, input logic [6:0] s0);
        rec_t r;
        r.value = v;
        r.en    = en;
        r.dpm   = dpm;
        r.vis   = vis;
        r.segs  = {s3, s2, s1, s0};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, s);
        end
    endtask

    // One clock: queue the expected pins for the cycle that starts at this edge
    task automatic cycle();
        exp_t e;
        int   di;
        int   ci;
        @(posedge clk);
        di = (s % FRAME) / RD;
        ci = s % RD;
        e.anode = 4'hF;
        e.seg   = 7'h7F;
        e.dp    = 1'b1;
        if (ci >= BC && shadow.vis[di]) begin
            e.anode = ~(4'b0001 << di);
            e.seg   = shadow.segs[di];
            e.dp    = ~shadow.dpm[di];
        end
        if (s % FRAME == FRAME - 1) shadow = drv;
        s++;
        e.fs = (s % FRAME == 0);
        sbq.push_back(e);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic apply(input int r);
        drv      = tbl[r];
        value    = tbl[r].value;
        digit_en = tbl[r].en;
        dp_in    = tbl[r].dpm;
    endtask

    // Scoreboard: compare DUT pins against the queued expectation mid-cycle
    always @(negedge clk) begin
        if (rst_n === 1'b1 && sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            check("anode", 32'(anode), 32'(e.anode));
            check("seg", 32'(seg), 32'(e.seg));
            check("dp", 32'(dp), 32'(e.dp));
            check("frame_start", 32'(frame_start), 32'(e.fs));
        end
    end

    initial begin
        rst_n    = 1'b0;
        value    = '0;
        digit_en = '0;
        dp_in    = '0;
        zrec     = mk(16'h0, 4'h0, 4'h0, 4'h0, 7'h0, 7'h0, 7'h0, 7'h0);
        drv      = zrec;
        shadow   = zrec;

        tbl[0] = mk(16'h1234, 4'hF, 4'h0, 4'hF, 7'h79, 7'h24, 7'h30, 7'h19);
        tbl[1] = mk(16'hABCD, 4'hF, 4'h0, 4'hF, 7'h08, 7'h03, 7'h46, 7'h21);
        tbl[2] = mk(16'h1234, 4'b0101, 4'b0100, 4'b0101, 7'h79, 7'h24, 7'h30, 7'h19);
        tbl[3] = mk(16'h0050, 4'hF, 4'h0, VIS_0050, 7'h40, 7'h40, 7'h12, 7'h40);
        tbl[4] = mk(16'h0000, 4'hF, 4'h0, VIS_0000, 7'h40, 7'h40, 7'h40, 7'h40);
        tbl[5] = mk(16'h89EF, 4'hF, 4'hF, 4'hF, 7'h00, 7'h10, 7'h06, 7'h0E);
        tbl[6] = mk(16'h5670, 4'b1110, 4'b1010, 4'b1110, 7'h12, 7'h02, 7'h78, 7'h40);

        // Held in reset
        repeat (5) @(posedge clk);
        #1;
        check("rst_anode", 32'(anode), 32'h0F);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        check("rst_fs", 32'(frame_start), 32'h0);

        @(posedge clk);
        #2;
        rst_n = 1'b1;
        s     = 0;

        // First frame after reset is blank even with inputs applied
        apply(0);
        run(FRAME);

        // Table: each record is latched at the next frame boundary and shown for a frame
        for (int r = 0; r < 7; r++) begin
            apply(r);
            run(2 * FRAME);
        end

        // Tearing: switch the word while digit 1 is on screen
        apply(0);
        run(FRAME);
        run(6);
        check("tear_pre_anode", 32'(anode), 32'b1101);
        apply(1);
        run(5);
        check("tear_hold_anode", 32'(anode), 32'b1011);
        check("tear_hold_seg", 32'(seg), 32'h24);
        run(5);
        run(6);
        check("tear_new_seg", 32'(seg), 32'h46);
        run(10);

        // Asynchronous reset while digit 2 is lit
        apply(0);
        run(FRAME);
        run(10);
        check("mid_pre_anode", 32'(anode), 32'b1011);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_anode", 32'(anode), 32'h0F);
        check("mid_rst_seg", 32'(seg), 32'h7F);
        check("mid_rst_dp", 32'(dp), 32'h1);
        check("mid_rst_fs", 32'(frame_start), 32'h0);
        sbq.delete();
        repeat (3) @(posedge clk);
        #2;
        rst_n  = 1'b1;
        s      = 0;
        shadow = zrec;
        run(2 * FRAME + 1);

        @(negedge clk);
        #1;
        check("sb_drain", 32'(sbq.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Time-multiplexed driver for an N-digit common-anode 7-segment display bank.
- Takes a packed hex word plus per-digit enable and decimal-point masks, and scans one digit per slot.
- Drives active-low segment, dp and anode lines.
- Latches the input word once per frame so digits never tear; sits between the datapath/encoder and the board display pins.

Parameters:
- NUM_DIGITS, 8, number of digits/anodes scanned (1..16).
- REFRESH_DIV, 100000, clock cycles per digit slot (>=2).
- BLANK_CYCLES, 1, cycles at the start of each slot with all anodes off for anti-ghosting (0 <= BLANK_CYCLES < REFRESH_DIV).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- value  in  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) is digit i, digit 0 rightmost
- digit_en  in  NUM_DIGITS  1 = digit i displayed, 0 = blanked
- dp_in  in  NUM_DIGITS  1 = decimal point lit on digit i
- seg  out  7  active-low segments, seg[0]=a ... seg[6]=g
- dp  out  1  active-low decimal point
- anode  out  NUM_DIGITS  active-low digit enables, at most one low at any time
- frame_start  out  1  one-cycle pulse when scanning wraps to digit 0

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: anode all 1, seg=7'h7F, dp=1, frame_start=0.
  - State: slot counter cnt=0, digit index idx=0, shadow register=0.
  - Outputs go blank immediately, without waiting for a clock edge.
- Slot counter:
  - cnt counts 0..REFRESH_DIV-1.
  - At cnt=REFRESH_DIV-1, cnt wraps to 0 and idx advances.
  - idx wraps NUM_DIGITS-1 -> 0.
- Shadow load:
  - On the edge where (idx=NUM_DIGITS-1, cnt=REFRESH_DIV-1), shadow <= {value, digit_en, dp_in}.
  - frame_start is 1 during the following cycle (state (0,0)).
  - First frame after reset therefore shows shadow=0, i.e. all digits disabled, fully blank.
- Outputs are registered. Outputs in cycle t+1 reflect (idx, cnt, shadow) in cycle t, so latency is 1 cycle.
- Output function for state (idx, cnt):
  - If cnt < BLANK_CYCLES or shadow digit_en[idx]=0: anode all 1, seg=7'h7F, dp=1.
  - Otherwise: anode = ~(1<<idx), seg = hex decode of shadow nibble idx, dp = ~shadow dp_in[idx].
- Hex decode (active low, g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Changes on value, digit_en or dp_in mid-frame have no visible effect until the next frame_start.
- NUM_DIGITS=1: idx is constant 0, and frame_start pulses every REFRESH_DIV cycles.
- Counter widths are $clog2-derived; no overflow is possible under the parameter constraints.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - At shadow load, every digit above the most-significant nonzero nibble is treated as disabled, giving its blank output.
  - Digit 0 always follows its own digit_en, so a value of 0 still shows a single "0".
- Undefined: no suppression; zeros are displayed per digit_en.

Decomposition:
- Package seven_seg_pkg:
  - Constants: SEG_BLANK=7'h7F, ANODE_OFF (all 1).
  - Function hex_to_seg(logic [3:0]) returning logic [6:0].
- Sub-module hex_to_seven_seg: purely combinational nibble-to-segment decoder using the package function, instantiated once on the muxed nibble.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1 unless noted):
- Reset: hold rst_n=0 for 5 cycles -> anode=4'hF, seg=7'h7F, dp=1, frame_start=0. Release -> first frame fully blank.
- Scan order: value=16'h1234, digit_en=4'hF, dp_in=0.
  - From the second frame, each slot is 1 cycle of anode=F followed by 3 cycles of the digit.
  - anode/seg sequence: 1110/19, 1101/30, 1011/24, 0111/79.
  - frame_start pulses every 16 cycles.
- Tearing: change value to 16'hABCD during digit 1 -> remaining slots keep showing 2,1. After the next frame_start, seg shows 21,46,03,08.
- Enables and dp: digit_en=4'b0101, dp_in=4'b0100.
  - Slots 1 and 3 show anode=F, seg=7F.
  - dp=0 only during the 3 active cycles of digit 2.
- Mid-frame reset: assert rst_n=0 during digit 2 active -> outputs blank in the same cycle. After release, idx=0 and the first frame is blank.
- Leading zeros: value=16'h0050, digit_en=4'hF.
  - With SEVEN_SEG_LEADING_ZERO_BLANK_EN: digits 3 and 2 blank, digit 1 = 12, digit 0 = 40.
  - Without it: 40, 40, 12, 40.
  - value=0 with the macro: only digit 0 lit, showing 40.
